// File: rtl/gimbal_rate_ctrl_if.sv
// Sample/command bundle between the flight computer and the gimbal rate controller.
// The master side supplies velocity/height samples; the slave side returns the rate command.
interface gimbal_rate_ctrl_if #(
    parameter int unsigned W  = 64,
    parameter int unsigned OW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  velocity;
    logic [W-1:0]  height;
    logic [1:0]    mode;
    logic          gimbal_en;
    logic [OW-1:0] omega;
    logic          omega_valid;
    logic          omega_sat;
    logic          busy;

    modport master (
        output in_valid, velocity, height, mode,
        input  in_ready, gimbal_en, omega, omega_valid, omega_sat, busy
    );

    modport slave (
        input  in_valid, velocity, height, mode,
        output in_ready, gimbal_en, omega, omega_valid, omega_sat, busy
    );
endinterface

// File: rtl/gimbal_rate_ctrl.sv
// Orbital angular-rate command: omega = velocity / (R0 + height) via a restoring divider,
// followed by clamp, mode-dependent target selection and slew limiting. Gimbal enable uses altitude hysteresis.
module gimbal_rate_ctrl #(
    parameter int unsigned     W        = 64,
    parameter int unsigned     FRAC     = 16,
    parameter int unsigned     OW       = 32,
    parameter longint unsigned R0       = 64'd6371000000,
    parameter longint unsigned ON_ALT   = 64'd30000000,
    parameter longint unsigned OFF_ALT  = 64'd29000000,
    parameter longint unsigned MAX_STEP = 64'd64
) (
    input  logic              clk,
    input  logic              resetb,
    gimbal_rate_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_LIMIT
    } state_e;

    localparam int unsigned DW  = W + FRAC;
    localparam int unsigned VW  = W + 1;
    localparam int unsigned OW1 = OW + 1;
    localparam int unsigned XW  = (DW > OW) ? DW : OW;
    localparam int unsigned CW  = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [1:0]    MODE_OFF  = 2'b00;
    localparam logic [1:0]    MODE_AUTO = 2'b01;
    localparam logic [W-1:0]  ON_W      = W'(ON_ALT);
    localparam logic [W-1:0]  OFF_W     = W'(OFF_ALT);
    localparam logic [VW-1:0] R0_V      = VW'(R0);
    localparam logic [OW:0]   STEP_E    = OW1'(MAX_STEP);
    localparam logic [OW-1:0] STEP_O    = OW'(MAX_STEP);
    localparam logic [XW-1:0] QMAX_X    = XW'({OW{1'b1}});

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] dq_q, dq_d;
    logic [VW-1:0] rem_q, rem_d;
    logic [VW-1:0] div_q;
    logic [1:0]    mode_q;
    logic          gimbal_en_q, gimbal_en_d;
    logic [OW-1:0] omega_q, omega_d;
    logic          omega_valid_q;
    logic          omega_sat_q, sat_d;
    logic          busy_q;
    logic          accept;

    logic [VW:0]   trial;
    logic [XW-1:0] q_ext;
    logic [OW-1:0] quot_c;
    logic [OW-1:0] target;
    logic [OW:0]   omega_e, target_e;

    assign bus.in_ready    = (state_q == S_IDLE) && !resetb;
    assign accept          = bus.in_valid && bus.in_ready;
    assign bus.gimbal_en   = gimbal_en_q;
    assign bus.omega       = omega_q;
    assign bus.omega_valid = omega_valid_q;
    assign bus.omega_sat   = omega_sat_q;
    assign bus.busy        = busy_q;

    // One restoring step: dq_q shifts the dividend out at the top and the quotient in at the bottom.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        trial = {rem_q, dq_q[DW-1]};
        dq_d  = {dq_q[DW-2:0], 1'b0};
        rem_d = trial[VW-1:0];
        if (trial >= {1'b0, div_q}) begin
            rem_d   = VW'(trial - {1'b0, div_q});
            dq_d[0] = 1'b1;
        end
    end

    always_comb begin
        gimbal_en_d = gimbal_en_q;
        if (bus.mode == MODE_OFF) begin
            gimbal_en_d = 1'b0;
        end else if (bus.height > ON_W) begin
            gimbal_en_d = 1'b1;
        end else if (bus.height < OFF_W) begin
            gimbal_en_d = 1'b0;
        end
    end

    // Slew comparisons are one bit wider than omega so omega +/- MAX_STEP never wraps.
    always_comb begin
        q_ext  = XW'(dq_q);
        sat_d  = q_ext > QMAX_X;
        quot_c = sat_d ? {OW{1'b1}} : q_ext[OW-1:0];
        target = omega_q;
        if (mode_q == MODE_AUTO) begin
            target = gimbal_en_q ? quot_c : '0;
        end
        omega_e  = {1'b0, omega_q};
        target_e = {1'b0, target};
        if (mode_q == MODE_OFF) begin
            omega_d = '0;
        end else if (target_e > omega_e + STEP_E) begin
            omega_d = omega_q + STEP_O;
        end else if (target_e + STEP_E < omega_e) begin
            omega_d = omega_q - STEP_O;
        end else begin
            omega_d = target;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (resetb) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            dq_q          <= '0;
            rem_q         <= '0;
            div_q         <= '0;
            mode_q        <= MODE_OFF;
            gimbal_en_q   <= 1'b0;
            omega_q       <= '0;
            omega_valid_q <= 1'b0;
            omega_sat_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            omega_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        dq_q        <= DW'(bus.velocity) << FRAC;
                        rem_q       <= '0;
                        div_q       <= VW'(bus.height) + R0_V;
                        mode_q      <= bus.mode;
                        gimbal_en_q <= gimbal_en_d;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= S_DIV;
                    end
                end
                S_DIV: begin
                    dq_q  <= dq_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(DW - 1)) begin
                        state_q <= S_LIMIT;
                    end
                end
                S_LIMIT: begin
                    omega_q       <= omega_d;
                    omega_sat_q   <= sat_d;
                    omega_valid_q <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gimbal_rate_ctrl.sv
// Scoreboard bench for gimbal_rate_ctrl: three small configurations share one stimulus driver,
// a behavioural model queues expected updates and a negedge monitor retires them.
module tb_gimbal_rate_ctrl;

    localparam logic [1:0] M_OFF  = 2'b00;
    localparam logic [1:0] M_AUTO = 2'b01;
    localparam logic [1:0] M_HOLD = 2'b10;
    localparam int         LAT    = 25;

    typedef struct {
        longint omega;
        bit     sat;
        int     t_acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetb;
    logic [1:0]  sel;
    logic        in_valid;
    logic [15:0] velocity;
    logic [15:0] height;
    logic [1:0]  mode;

    logic        o_ready, o_en, o_valid, o_sat, o_busy;
    logic [15:0] o_omega;

    int     n_checks  = 0;
    int     n_errors  = 0;
    int     cyc       = 0;
    int     valid_cnt = 0;
    exp_t   sb_q[$];
    exp_t   mon_e;
    longint m_omega[3];
    bit     m_en[3];
    bit     m_sat[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gimbal_rate_ctrl_if #(.W(16), .OW(16)) if_a ();
    gimbal_rate_ctrl_if #(.W(16), .OW(16)) if_b ();
    gimbal_rate_ctrl_if #(.W(16), .OW(16)) if_c ();

    assign if_a.in_valid = in_valid && (sel == 2'd0);
    assign if_b.in_valid = in_valid && (sel == 2'd1);
    assign if_c.in_valid = in_valid && (sel == 2'd2);
    assign if_a.velocity = velocity;
    assign if_b.velocity = velocity;
    assign if_c.velocity = velocity;
    assign if_a.height   = height;
    assign if_b.height   = height;
    assign if_c.height   = height;
    assign if_a.mode     = mode;
    assign if_b.mode     = mode;
    assign if_c.mode     = mode;

    gimbal_rate_ctrl #(.W(16), .FRAC(8), .OW(16), .R0(1000), .ON_ALT(300), .OFF_ALT(250), .MAX_STEP(65535))
        u_dut_a (.clk(clk), .resetb(resetb), .bus(if_a));
    gimbal_rate_ctrl #(.W(16), .FRAC(8), .OW(16), .R0(1000), .ON_ALT(300), .OFF_ALT(250), .MAX_STEP(10))
        u_dut_b (.clk(clk), .resetb(resetb), .bus(if_b));
    gimbal_rate_ctrl #(.W(16), .FRAC(8), .OW(16), .R0(100), .ON_ALT(300), .OFF_ALT(250), .MAX_STEP(65535))
        u_dut_c (.clk(clk), .resetb(resetb), .bus(if_c));

    always_comb begin
        o_ready = if_a.in_ready;
        o_en    = if_a.gimbal_en;
        o_omega = if_a.omega;
        o_valid = if_a.omega_valid;
        o_sat   = if_a.omega_sat;
        o_busy  = if_a.busy;
        if (sel == 2'd1) begin
            o_ready = if_b.in_ready;
            o_en    = if_b.gimbal_en;
            o_omega = if_b.omega;
            o_valid = if_b.omega_valid;
            o_sat   = if_b.omega_sat;
            o_busy  = if_b.busy;
        end else if (sel == 2'd2) begin
            o_ready = if_c.in_ready;
            o_en    = if_c.gimbal_en;
            o_omega = if_c.omega;
            o_valid = if_c.omega_valid;
            o_sat   = if_c.omega_sat;
            o_busy  = if_c.busy;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint r0_of(input int d);
        return (d == 2) ? 64'sd100 : 64'sd1000;
    endfunction

    function automatic longint step_of(input int d);
        return (d == 1) ? 64'sd10 : 64'sd65535;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_omega[i] = 0;
            m_en[i]    = 1'b0;
            m_sat[i]   = 1'b0;
        end
    endtask

    task automatic model_accept(input logic [15:0] v, input logic [15:0] h, input logic [1:0] md);
        int     d = int'(sel);
        longint q, qc, tgt, cur, stp, nxt;
        bit     sat;
        exp_t   e;
        q   = (longint'(v) * 256) / (r0_of(d) + longint'(h));
        sat = q > 65535;
        qc  = sat ? 65535 : q;
        if (md == M_OFF)   m_en[d] = 1'b0;
        else if (h > 300)  m_en[d] = 1'b1;
        else if (h < 250)  m_en[d] = 1'b0;
        cur = m_omega[d];
        stp = step_of(d);
        tgt = (md == M_AUTO) ? (m_en[d] ? qc : 0) : cur;
        if (md == M_OFF)         nxt = 0;
        else if (tgt > cur + stp) nxt = cur + stp;
        else if (tgt + stp < cur) nxt = cur - stp;
        else                      nxt = tgt;
        m_omega[d] = nxt;
        m_sat[d]   = sat;
        e.omega = nxt;
        e.sat   = sat;
        e.t_acc = cyc;
        sb_q.push_back(e);
    endtask

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic send(input logic [15:0] v, input logic [15:0] h, input logic [1:0] md);
        int n = 0;
        while (o_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (o_ready !== 1'b1) check("ready_timeout", 64'(o_ready), 64'd1);
        velocity = v;
        height   = h;
        mode     = md;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        velocity = 16'($urandom);
        height   = 16'($urandom);
        mode     = 2'($urandom);
        model_accept(v, h, md);
        @(negedge clk);
        check("busy_after_accept", 64'(o_busy), 64'd1);
        check("ready_low_busy", 64'(o_ready), 64'd0);
        check("gimbal_en", 64'(o_en), 64'(m_en[sel]));
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) check("drain_timeout", 64'(sb_q.size()), 64'd0);
        check("ready_after_update", 64'(o_ready), 64'd1);
        check("sat_hold", 64'(o_sat), 64'(m_sat[sel]));
    endtask

    always @(negedge clk) begin
        if (resetb === 1'b0 && o_valid === 1'b1) begin
            valid_cnt++;
            check("valid_expected", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("omega", 64'(o_omega), 64'(mon_e.omega));
                check("omega_sat", 64'(o_sat), 64'(mon_e.sat));
                check("latency", 64'(cyc - mon_e.t_acc), 64'(LAT));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, n_errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        resetb   = 1'b1;
        sel      = 2'd0;
        in_valid = 1'b0;
        velocity = '0;
        height   = '0;
        mode     = M_OFF;
        model_reset();

        // Reset state and in_ready behaviour around release.
        repeat (3) begin
            @(negedge clk);
            check("rst_in_ready", 64'(o_ready), 64'd0);
        end
        check("rst_omega", 64'(o_omega), 64'd0);
        check("rst_gimbal_en", 64'(o_en), 64'd0);
        check("rst_omega_valid", 64'(o_valid), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        resetb = 1'b0;
        #1;
        check("rel_in_ready", 64'(o_ready), 64'd1);
        @(negedge clk);
        check("rel_omega_sat", 64'(o_sat), 64'd0);

        // Nominal AUTO sample and hysteresis band.
        send(16'd500, 16'd400, M_AUTO);
        drain();
        check("s2_omega_91", 64'(o_omega), 64'd91);
        send(16'd500, 16'd280, M_AUTO);
        drain();
        check("s3_band_hold_100", 64'(o_omega), 64'd100);
        send(16'd500, 16'd240, M_AUTO);
        drain();
        check("s3_disable_0", 64'(o_omega), 64'd0);
        send(16'd500, 16'd299, M_AUTO);
        drain();
        check("s3_stay_off", 64'(o_en), 64'd0);

        // Slew limiting with a 10-LSB step, then HOLD / OFF / mode 11.
        sel = 2'd1;
        for (int i = 0; i < 10; i++) begin
            send(16'd500, 16'd400, M_AUTO);
            drain();
        end
        check("s4_slew_final_91", 64'(o_omega), 64'd91);
        send(16'd500, 16'd400, M_HOLD);
        drain();
        check("s4_hold_91", 64'(o_omega), 64'd91);
        send(16'd500, 16'd400, M_OFF);
        drain();
        check("s4_off_0", 64'(o_omega), 64'd0);
        send(16'd500, 16'd400, M_AUTO);
        drain();
        send(16'd9000, 16'd400, 2'b11);
        drain();
        check("s4_mode3_hold_10", 64'(o_omega), 64'd10);

        // Quotient clamp and its release on the next sample.
        sel = 2'd2;
        send(16'd65535, 16'd0, M_AUTO);
        drain();
        check("s5_sat_set", 64'(o_sat), 64'd1);
        send(16'd100, 16'd400, M_AUTO);
        drain();
        send(16'd100, 16'd300, M_AUTO);
        drain();
        check("s5_omega_64", 64'(o_omega), 64'd64);
        check("s5_sat_clear", 64'(o_sat), 64'd0);

        // Reset in the middle of a division aborts it.
        sel = 2'd0;
        send(16'd500, 16'd400, M_AUTO);
        repeat (9) @(negedge clk);
        resetb = 1'b1;
        sb_q.delete();
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check("abort_in_ready_low", 64'(o_ready), 64'd0);
        end
        resetb = 1'b0;
        #1;
        check("abort_in_ready", 64'(o_ready), 64'd1);
        check("abort_omega", 64'(o_omega), 64'd0);
        check("abort_busy", 64'(o_busy), 64'd0);
        check("abort_gimbal_en", 64'(o_en), 64'd0);
        snap = valid_cnt;
        repeat (30) @(negedge clk);
        check("abort_no_valid", 64'(valid_cnt - snap), 64'd0);
        send(16'd500, 16'd400, M_AUTO);
        drain();
        check("abort_fresh_omega", 64'(o_omega), 64'd91);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
